// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU: single-cycle logic/arith, iterative shifts, shift-add multiply
module alu_multicycle #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1100;

  localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   result_nxt, result_hi_nxt;
  logic               zero_nxt, ovf_nxt, err_nxt, done_nxt;
  logic [WIDTH-1:0]   sh, sh_nxt, sh_step;
  logic [1:0]         shop, shop_nxt;
  logic [SHW:0]       cnt, cnt_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt, acc_step, mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;

  logic [WIDTH-1:0]   bop, sum, quick;
  logic               quick_ovf, quick_err, launch_shift, launch_mul;
  logic [SHW-1:0]     amt;

  assign busy = (state != IDLE);
  assign amt  = b[SHW-1:0];
  assign bop  = (control == OP_SUB) ? (~b + 1'b1) : b;
  assign sum  = a + bop;

  // Single-cycle result, or a request to enter an iterative state
  always_comb begin
    quick        = '0;
    quick_ovf    = 1'b0;
    quick_err    = 1'b0;
    launch_shift = 1'b0;
    launch_mul   = 1'b0;
    case (control)
      OP_AND: quick = a & b;
      OP_OR:  quick = a | b;
      OP_ADD, OP_SUB: begin
        quick     = sum;
        quick_ovf = (a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: quick = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL, OP_SRL, OP_SRA: begin
        if (amt == '0) quick = a;
        else           launch_shift = 1'b1;
      end
      OP_MUL:  launch_mul = 1'b1;
      default: quick_err = 1'b1;
    endcase
  end

  always_comb begin
    case (shop)
      2'b00:   sh_step = sh << 1;
      2'b01:   sh_step = sh >> 1;
      default: sh_step = {sh[WIDTH-1], sh[WIDTH-1:1]};
    endcase
    acc_step = mplier[0] ? (acc + mcand) : acc;
  end

  always_comb begin
    state_nxt     = state;
    result_nxt    = result;
    result_hi_nxt = result_hi;
    zero_nxt      = zero;
    ovf_nxt       = ovf;
    err_nxt       = err;
    done_nxt      = 1'b0;
    sh_nxt        = sh;
    shop_nxt      = shop;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    mcand_nxt     = mcand;
    mplier_nxt    = mplier;
    case (state)
      IDLE: begin
        if (start) begin
          if (launch_shift) begin
            state_nxt = SHIFT;
            sh_nxt    = a;
            shop_nxt  = control[1:0];
            cnt_nxt   = {1'b0, amt};
          end else if (launch_mul) begin
            state_nxt  = MUL;
            mcand_nxt  = {{WIDTH{1'b0}}, a};
            mplier_nxt = b;
            acc_nxt    = '0;
            cnt_nxt    = MUL_CNT;
          end else begin
            result_nxt    = quick;
            result_hi_nxt = '0;
            zero_nxt      = (quick == '0);
            ovf_nxt       = quick_ovf;
            err_nxt       = quick_err;
            done_nxt      = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_nxt  = sh_step;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_ONE) begin
          state_nxt     = IDLE;
          result_nxt    = sh_step;
          result_hi_nxt = '0;
          zero_nxt      = (sh_step == '0);
          ovf_nxt       = 1'b0;
          err_nxt       = 1'b0;
          done_nxt      = 1'b1;
        end
      end
      MUL: begin
        acc_nxt    = acc_step;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt - 1'b1;
        if (cnt == CNT_ONE) begin
          state_nxt     = IDLE;
          result_nxt    = acc_step[WIDTH-1:0];
          result_hi_nxt = acc_step[2*WIDTH-1:WIDTH];
          zero_nxt      = (acc_step[WIDTH-1:0] == '0);
          ovf_nxt       = 1'b0;
          err_nxt       = 1'b0;
          done_nxt      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      sh        <= '0;
      shop      <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      state     <= state_nxt;
      result    <= result_nxt;
      result_hi <= result_hi_nxt;
      zero      <= zero_nxt;
      ovf       <= ovf_nxt;
      err       <= err_nxt;
      done      <= done_nxt;
      sh        <= sh_nxt;
      shop      <= shop_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized self-checking bench for alu_multicycle against an arithmetic model
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  control = 4'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result, result_hi;
  logic        zero, ovf, err, busy, done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_last = '0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .control(control), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .zero(zero), .ovf(ovf),
    .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic ov, output logic er, output int lat);
    longint s;
    longint lim;
    longint unsigned p;
    logic [31:0] bp;
    int n;
    lo = '0; hi = '0; ov = 1'b0; er = 1'b0; lat = 0;
    lim = 64'sh7FFFFFFF;
    n = int'(bv[4:0]);
    case (c)
      4'b0000: lo = av & bv;
      4'b0001: lo = av | bv;
      4'b0010: begin
        s  = longint'($signed(av)) + longint'($signed(bv));
        lo = s[31:0];
        ov = (s > lim) || (s < -lim - 1);
      end
      4'b0110: begin
        bp = 32'd0 - bv;
        s  = longint'($signed(av)) + longint'($signed(bp));
        lo = s[31:0];
        ov = (s > lim) || (s < -lim - 1);
      end
      4'b0111: lo = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      4'b1000: begin lo = av << n; lat = n; end
      4'b1001: begin lo = av >> n; lat = n; end
      4'b1010: begin lo = $signed(av) >>> n; lat = n; end
      4'b1100: begin
        p   = {32'd0, av} * {32'd0, bv};
        lo  = p[31:0];
        hi  = p[63:32];
        lat = 32;
      end
      default: er = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv, input bit poke);
    logic [31:0] elo, ehi;
    logic eov, eer;
    int lat, seen;
    model(c, av, bv, elo, ehi, eov, eer, lat);
    @(negedge clk);
    start = 1'b1; control = c; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, (lat > 0));
    seen = -1;
    if (done) seen = 0;
    else begin
      chk("hold_while_busy", result, exp_last);
      for (int i = 1; i <= 100 && seen < 0; i++) begin
        if (poke && lat >= 2 && i == 2) begin
          start = 1'b1; control = 4'b0010; a = $urandom; b = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (done) seen = i;
      end
    end
    chk("latency", seen, lat);
    chk("result", result, elo);
    chk("result_hi", result_hi, ehi);
    chk("zero", zero, (elo == 32'd0));
    chk("ovf", ovf, eov);
    chk("err", err, eer);
    exp_last = elo;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int ndone;
    logic [3:0] rc;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_flags", {zero, ovf, err, busy, done}, 5'b0);
    @(negedge clk) rst = 1'b0;

    run_op(4'b0000, 32'd10, 32'd7, 0);
    run_op(4'b0001, 32'd10, 32'd7, 0);
    run_op(4'b0010, 32'd10, 32'd7, 0);
    run_op(4'b0110, 32'd10, 32'd7, 0);
    run_op(4'b0111, 32'd10, 32'd7, 0);
    run_op(4'b0111, 32'hFFFFFFFF, 32'd1, 0);
    run_op(4'b0010, 32'h7FFFFFFF, 32'd1, 0);
    run_op(4'b0110, 32'h80000000, 32'd1, 0);
    run_op(4'b1010, 32'h80000000, 32'd4, 1);
    run_op(4'b1001, 32'h12345678, 32'd0, 0);
    run_op(4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    run_op(4'b1100, 32'd6, 32'd7, 0);
    run_op(4'b0011, 32'h55, 32'hAA, 0);
    run_op(4'b0000, 32'hF0, 32'h3C, 0);

    // back-to-back: start still high in the done cycle launches SUB
    @(negedge clk);
    start = 1'b1; control = 4'b0010; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    chk("b2b_done1", done, 1'b1);
    chk("b2b_res1", result, 32'd7);
    control = 4'b0110; a = 32'd9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done2", done, 1'b1);
    chk("b2b_res2", result, 32'd7);
    exp_last = 32'd7;

    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; control = 4'b1100; a = 32'hFFFFFFFF; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_hi", result_hi, 0);
    chk("midrst_flags", {zero, ovf, err, busy, done}, 5'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    exp_last = '0;
    run_op(4'b0010, 32'd1, 32'd1, 0);

    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      run_op(rc, $urandom, $urandom, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
